// File: rtl/proc_param.sv
// Parametrised multicycle processor: 10-bit instructions from a synchronous ROM,
// load/store to a synchronous RAM, 3 steps per instruction (4 for mvi and ld).
module proc_param #(
   parameter int unsigned DATA_W = 16,
   parameter int unsigned NREG   = 8,
   parameter int unsigned PC_W   = 6,
   parameter int unsigned ADDR_W = 7
) (
   input  logic                   clock,
   input  logic                   reset,
   input  logic                   run,
   input  logic [DATA_W-1:0]      DIN,
   input  logic [DATA_W-1:0]      memout,
   output logic                   Done,
   output logic [DATA_W-1:0]      BusWires,
   output logic                   write,
   output logic [PC_W-1:0]        pc,
   output logic [ADDR_W-1:0]      address,
   output logic [DATA_W-1:0]      dataout,
   output logic [9:0]             IR,
   output logic [1:0]             Tstep,
   output logic [NREG*DATA_W-1:0] regs,
   output logic                   halted
);

   localparam int unsigned IR_W     = 10;
   localparam int unsigned RF_SLOTS = 8;

   localparam logic [3:0] OP_MV   = 4'd0;
   localparam logic [3:0] OP_MVI  = 4'd1;
   localparam logic [3:0] OP_ADD  = 4'd2;
   localparam logic [3:0] OP_SUB  = 4'd3;
   localparam logic [3:0] OP_LD   = 4'd4;
   localparam logic [3:0] OP_ST   = 4'd5;
   localparam logic [3:0] OP_MVNZ = 4'd6;
   localparam logic [3:0] OP_AND  = 4'd7;
   localparam logic [3:0] OP_JNZ  = 4'd8;
   localparam logic [3:0] OP_HALT = 4'd9;

   typedef enum logic [2:0] {
      S_IDLE,
      S_FETCH,
      S_DECODE,
      S_EXEC1,
      S_EXEC2,
      S_HALT
   } state_t;

   state_t              state_q, state_d;
   logic [PC_W-1:0]     pc_d;
   logic [IR_W-1:0]     ir_d;
   logic [ADDR_W-1:0]   address_d;
   logic [DATA_W-1:0]   dataout_d;
   logic                write_d;
   logic                z_q, z_d;
   logic [1:0]          tstep_d;
   logic                halted_d;

   logic                rf_we;
   logic [2:0]          rf_widx;
   logic [DATA_W-1:0]   rf_wdata;
   logic [DATA_W-1:0]   rf [RF_SLOTS];

   logic [IR_W-1:0]     din_ir;
   logic [3:0]          op, d_op;
   logic [DATA_W-1:0]   rx_v, ry_v, d_rx_v, d_ry_v;
   logic [DATA_W-1:0]   alu_y;

   // ROM word as a 10-bit instruction; narrow data paths are zero-extended
   if (DATA_W >= IR_W) begin : g_ir_wide
      assign din_ir = DIN[IR_W-1:0];
   end else begin : g_ir_narrow
      assign din_ir = {{(IR_W-DATA_W){1'b0}}, DIN};
   end

   // Register file: slots at or above NREG read as zero and ignore writes
   for (genvar g = 0; g < RF_SLOTS; g++) begin : g_rf
      if (g < NREG) begin : g_impl
         logic [DATA_W-1:0] q;
         // One general register
         always_ff @(posedge clock or negedge reset) begin
            if (!reset)                           q <= '0;
            else if (rf_we && rf_widx == 3'(g))   q <= rf_wdata;
         end
         assign rf[g] = q;
         assign regs[g*DATA_W +: DATA_W] = q;
      end else begin : g_none
         assign rf[g] = '0;
      end
   end

   assign op     = IR[9:6];
   assign rx_v   = rf[IR[5:3]];
   assign ry_v   = rf[IR[2:0]];
   assign d_op   = din_ir[9:6];
   assign d_rx_v = rf[din_ir[5:3]];
   assign d_ry_v = rf[din_ir[2:0]];

   // ALU for add, sub and and
   always_comb begin
      alu_y = '0;
      case (op)
         OP_ADD:  alu_y = rx_v + ry_v;
         OP_SUB:  alu_y = rx_v - ry_v;
         OP_AND:  alu_y = rx_v & ry_v;
         default: alu_y = '0;
      endcase
   end

   // Next-state, datapath control and step outputs
   always_comb begin
      state_d   = state_q;
      pc_d      = pc;
      ir_d      = IR;
      address_d = address;
      dataout_d = dataout;
      write_d   = 1'b0;
      z_d       = z_q;
      rf_we     = 1'b0;
      rf_widx   = IR[5:3];
      rf_wdata  = '0;
      Done      = 1'b0;
      BusWires  = '0;

      case (state_q)
         S_IDLE: begin
            if (run) state_d = S_FETCH;
         end

         S_FETCH: begin
            pc_d    = pc + PC_W'(1);
            state_d = S_DECODE;
         end

         // Memory operands are set up here so the RAM sees them during EXEC1
         S_DECODE: begin
            ir_d    = din_ir;
            state_d = S_EXEC1;
            if (d_op == OP_LD) begin
               address_d = d_ry_v[ADDR_W-1:0];
            end else if (d_op == OP_ST) begin
               address_d = d_ry_v[ADDR_W-1:0];
               dataout_d = d_rx_v;
               write_d   = 1'b1;
            end
         end

         S_EXEC1: begin
            Done = 1'b1;
            case (op)
               OP_MV: begin
                  rf_we    = 1'b1;
                  rf_wdata = ry_v;
                  BusWires = ry_v;
               end
               OP_MVI: begin
                  Done = 1'b0;
                  pc_d = pc + PC_W'(1);
               end
               OP_ADD, OP_SUB, OP_AND: begin
                  rf_we    = 1'b1;
                  rf_wdata = alu_y;
                  BusWires = alu_y;
                  z_d      = (alu_y == '0);
               end
               OP_LD: begin
                  Done = 1'b0;
               end
               OP_ST: begin
                  BusWires = rx_v;
               end
               OP_MVNZ: begin
                  if (!z_q) begin
                     rf_we    = 1'b1;
                     rf_wdata = ry_v;
                     BusWires = ry_v;
                  end
               end
               OP_JNZ: begin
                  BusWires = DATA_W'(ry_v[PC_W-1:0]);
                  if (rx_v != '0) pc_d = ry_v[PC_W-1:0];
               end
               default: ;
            endcase
            if (!Done)               state_d = S_EXEC2;
            else if (op == OP_HALT)  state_d = S_HALT;
            else if (run)            state_d = S_FETCH;
            else                     state_d = S_IDLE;
         end

         // Second step of mvi (ROM word) and ld (RAM word)
         S_EXEC2: begin
            Done     = 1'b1;
            rf_we    = 1'b1;
            rf_wdata = (op == OP_MVI) ? DIN : memout;
            BusWires = rf_wdata;
            state_d  = run ? S_FETCH : S_IDLE;
         end

         S_HALT: begin
            state_d = S_HALT;
         end

         default: state_d = S_IDLE;
      endcase
   end

   // Step number and halt flag for the state being entered
   always_comb begin
      tstep_d  = 2'd0;
      halted_d = (state_d == S_HALT);
      case (state_d)
         S_DECODE: tstep_d = 2'd1;
         S_EXEC1:  tstep_d = 2'd2;
         S_EXEC2:  tstep_d = 2'd3;
         default:  tstep_d = 2'd0;
      endcase
   end

   // State and control registers
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q <= S_IDLE;
         pc      <= '0;
         IR      <= '0;
         address <= '0;
         dataout <= '0;
         write   <= 1'b0;
         z_q     <= 1'b1;
         Tstep   <= 2'd0;
         halted  <= 1'b0;
      end else begin
         state_q <= state_d;
         pc      <= pc_d;
         IR      <= ir_d;
         address <= address_d;
         dataout <= dataout_d;
         write   <= write_d;
         z_q     <= z_d;
         Tstep   <= tstep_d;
         halted  <= halted_d;
      end
   end

endmodule

// File: tb/tb_proc_param.sv
// Scoreboard bench for proc_param: a 16-bit/8-register core running a directed
// program, and an 8-bit/4-register core exercising narrow data and missing registers.
module tb_proc_param;

   logic clock = 1'b0;
   always #5 clock = ~clock;

   // core 1: DATA_W=16, NREG=8
   logic         reset1, run1;
   logic [15:0]  din1, memout1, bus1, dataout1;
   logic         done1, write1, halted1;
   logic [5:0]   pc1;
   logic [6:0]   address1;
   logic [9:0]   ir1;
   logic [1:0]   tstep1;
   logic [127:0] regs1;

   // core 2: DATA_W=8, NREG=4
   logic         reset2, run2;
   logic [7:0]   din2, memout2, bus2, dataout2;
   logic         done2, write2, halted2;
   logic [5:0]   pc2;
   logic [6:0]   address2;
   logic [9:0]   ir2;
   logic [1:0]   tstep2;
   logic [31:0]  regs2;

   proc_param #(.DATA_W(16), .NREG(8), .PC_W(6), .ADDR_W(7)) dut1 (
      .clock(clock), .reset(reset1), .run(run1), .DIN(din1), .memout(memout1),
      .Done(done1), .BusWires(bus1), .write(write1), .pc(pc1), .address(address1),
      .dataout(dataout1), .IR(ir1), .Tstep(tstep1), .regs(regs1), .halted(halted1));

   proc_param #(.DATA_W(8), .NREG(4), .PC_W(6), .ADDR_W(7)) dut2 (
      .clock(clock), .reset(reset2), .run(run2), .DIN(din2), .memout(memout2),
      .Done(done2), .BusWires(bus2), .write(write2), .pc(pc2), .address(address2),
      .dataout(dataout2), .IR(ir2), .Tstep(tstep2), .regs(regs2), .halted(halted2));

   logic [15:0] rom1 [64];
   logic [15:0] ram1 [128];
   logic [7:0]  rom2 [64];

   // Synchronous ROMs and RAM
   always @(posedge clock) begin
      din1 <= rom1[pc1];
      din2 <= rom2[pc2];
      if (write1) ram1[address1] <= dataout1;
      memout1 <= ram1[address1];
   end

   int cyc = 0;
   int base1 = 0;
   always @(posedge clock) cyc <= cyc + 1;

   int n_checks = 0;
   int n_err = 0;

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   typedef struct {
      string       name;
      logic [1:0]  t;
      bit          cb;
      logic [15:0] bus;
      int          ridx;
      logic [15:0] rv;
      bit          cp;
      logic [5:0]  pcv;
      int          cyc;
      logic [31:0] vec;
   } exp_t;

   exp_t q1[$];
   exp_t q2[$];

   function automatic exp_t mk(string n, int t, int cb, int bus, int ri, int rv,
                               int cp, int pcv, int c, int vec);
      exp_t e;
      e.name = n;  e.t = 2'(t);  e.cb = (cb != 0);  e.bus = 16'(bus);
      e.ridx = ri; e.rv = 16'(rv); e.cp = (cp != 0); e.pcv = 6'(pcv);
      e.cyc = c;   e.vec = 32'(vec);
      return e;
   endfunction

   function automatic logic [15:0] enc(int op, int rx, int ry);
      return 16'({op[3:0], rx[2:0], ry[2:0]});
   endfunction

   // Monitor core 1: step/bus/timing at Done, register and pc after the edge
   exp_t p1;
   bit   p1v = 1'b0;
   always @(negedge clock) begin
      if (p1v) begin
         p1v = 1'b0;
         if (p1.ridx >= 0) chk({p1.name, " reg"}, 128'(regs1[p1.ridx*16 +: 16]), 128'(p1.rv));
         if (p1.cp) chk({p1.name, " pc"}, 128'(pc1), 128'(p1.pcv));
      end
      if (reset1 && done1) begin
         if (q1.size() == 0) chk("unexpected Done core1", 128'(done1), 128'(0));
         else begin
            p1  = q1.pop_front();
            p1v = 1'b1;
            chk({p1.name, " Tstep"}, 128'(tstep1), 128'(p1.t));
            if (p1.cb) chk({p1.name, " BusWires"}, 128'(bus1), 128'(p1.bus));
            if (p1.cyc > 0) chk({p1.name, " Done cycle"}, 128'(cyc - base1), 128'(p1.cyc));
         end
      end
   end

   // Monitor core 2: whole register vector after each expected Done
   exp_t p2;
   bit   p2v = 1'b0;
   always @(negedge clock) begin
      if (p2v) begin
         p2v = 1'b0;
         chk({p2.name, " regs"}, 128'(regs2), 128'(p2.vec));
      end
      if (reset2 && done2 && q2.size() != 0) begin
         p2  = q2.pop_front();
         p2v = 1'b1;
         chk({p2.name, " Tstep"}, 128'(tstep2), 128'(p2.t));
         chk({p2.name, " BusWires"}, 128'(bus2), 128'(p2.bus[7:0]));
      end
   end

   // Store monitor: every write cycle must carry the expected address and data
   int wr_cnt = 0;
   always @(negedge clock) begin
      if (reset1 && write1) begin
         wr_cnt++;
         chk("st address", 128'(address1), 128'(16'h10));
         chk("st data", 128'(dataout1), 128'(16'd6));
      end
   end

   task automatic check_reset1(input string tag);
      chk({tag, " pc"},       128'(pc1),      128'(0));
      chk({tag, " IR"},       128'(ir1),      128'(0));
      chk({tag, " Tstep"},    128'(tstep1),   128'(0));
      chk({tag, " Done"},     128'(done1),    128'(0));
      chk({tag, " write"},    128'(write1),   128'(0));
      chk({tag, " address"},  128'(address1), 128'(0));
      chk({tag, " dataout"},  128'(dataout1), 128'(0));
      chk({tag, " BusWires"}, 128'(bus1),     128'(0));
      chk({tag, " regs"},     regs1,          128'(0));
      chk({tag, " halted"},   128'(halted1),  128'(0));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int bad;
      reset1 = 1'b0; run1 = 1'b0; reset2 = 1'b0; run2 = 1'b0; memout2 = '0;
      for (int i = 0; i < 64; i++) begin
         rom1[i] = enc(10, 0, 0);
         rom2[i] = '0;
      end
      for (int i = 0; i < 128; i++) ram1[i] = '0;

      // core 1 program
      rom1[0]  = enc(1, 0, 0);  rom1[1]  = 16'd5;
      rom1[2]  = enc(1, 1, 0);  rom1[3]  = 16'd3;
      rom1[4]  = enc(2, 0, 1);
      rom1[5]  = enc(3, 0, 0);
      rom1[6]  = enc(6, 2, 1);
      rom1[7]  = enc(2, 1, 1);
      rom1[8]  = enc(6, 2, 1);
      rom1[9]  = enc(1, 3, 0);  rom1[10] = 16'h10;
      rom1[11] = enc(5, 1, 3);
      rom1[12] = enc(4, 4, 3);
      rom1[13] = enc(7, 4, 3);
      rom1[14] = enc(1, 0, 0);  rom1[15] = 16'd3;
      rom1[16] = enc(1, 1, 0);  rom1[17] = 16'd1;
      rom1[18] = enc(1, 2, 0);  rom1[19] = 16'd20;
      rom1[20] = enc(3, 0, 1);
      rom1[21] = enc(8, 0, 2);
      rom1[22] = enc(1, 7, 0);  rom1[23] = 16'd61;
      rom1[24] = enc(8, 7, 7);
      rom1[61] = enc(1, 5, 0);  rom1[62] = 16'hAB;
      rom1[63] = enc(9, 0, 0);

      // core 2 program (8-bit words)
      rom2[0] = 8'(enc(1, 1, 0)); rom2[1] = 8'h05;
      rom2[2] = 8'(enc(0, 6, 1));
      rom2[3] = 8'(enc(0, 1, 6));
      rom2[4] = 8'(enc(1, 0, 0)); rom2[5] = 8'hFF;
      rom2[6] = 8'(enc(1, 1, 0)); rom2[7] = 8'h01;
      rom2[8] = 8'(enc(2, 0, 1));

      repeat (3) @(negedge clock);
      check_reset1("reset");
      chk("core2 reset regs", 128'(regs2), 128'(0));
      chk("core2 reset pc", 128'(pc2), 128'(0));

      //          name           t cb bus   ri rv  cp pc cyc vec
      q1.push_back(mk("mvi R0,5",    3, 1, 5,    0, 5,    0, 0, 4,  0));
      q1.push_back(mk("mvi R1,3",    3, 1, 3,    1, 3,    0, 0, 8,  0));
      q1.push_back(mk("add R0,R1",   2, 1, 8,    0, 8,    0, 0, 11, 0));
      q1.push_back(mk("sub R0,R0",   2, 1, 0,    0, 0,    0, 0, 0,  0));
      q1.push_back(mk("mvnz Z=1",    2, 0, 0,    2, 0,    0, 0, 0,  0));
      q1.push_back(mk("add R1,R1",   2, 1, 6,    1, 6,    0, 0, 0,  0));
      q1.push_back(mk("mvnz Z=0",    2, 1, 6,    2, 6,    0, 0, 0,  0));
      q1.push_back(mk("mvi R3,10h",  3, 1, 16,   3, 16,   0, 0, 0,  0));
      q1.push_back(mk("st R1,[R3]",  2, 1, 6,   -1, 0,    0, 0, 0,  0));
      q1.push_back(mk("ld R4,[R3]",  3, 1, 6,    4, 6,    0, 0, 0,  0));
      q1.push_back(mk("and R4,R3",   2, 1, 0,    4, 0,    0, 0, 0,  0));
      q1.push_back(mk("mvi R0,3",    3, 1, 3,    0, 3,    0, 0, 0,  0));
      q1.push_back(mk("mvi R1,1",    3, 1, 1,    1, 1,    0, 0, 0,  0));
      q1.push_back(mk("mvi R2,20",   3, 1, 20,   2, 20,   0, 0, 0,  0));
      for (int k = 2; k >= 0; k--) begin
         q1.push_back(mk($sformatf("loop sub %0d", k), 2, 1, k, 0, k, 0, 0, 0, 0));
         q1.push_back(mk($sformatf("loop jnz %0d", k), 2, 0, 0, -1, 0, 1, (k != 0) ? 20 : 22, 0, 0));
      end
      q1.push_back(mk("mvi R7,61",   3, 1, 61,   7, 61,   0, 0, 0,  0));
      q1.push_back(mk("jnz R7,R7",   2, 0, 0,   -1, 0,    1, 61, 0, 0));
      q1.push_back(mk("mvi R5,ABh",  3, 1, 171,  5, 171,  0, 0, 0,  0));
      q1.push_back(mk("halt wrap",   2, 1, 0,   -1, 0,    1, 0, 0,  0));

      run1   = 1'b1;
      base1  = cyc;
      reset1 = 1'b1;

      for (int i = 0; i < 3000 && !halted1; i++) @(negedge clock);
      chk("core1 reached HALT", 128'(halted1), 128'(1));
      repeat (2) @(negedge clock);
      chk("core1 queue drained", 128'(q1.size()), 128'(0));
      chk("write pulse count", 128'(wr_cnt), 128'(1));

      bad = 0;
      repeat (20) begin
         @(negedge clock);
         if (pc1 !== 6'd0 || halted1 !== 1'b1 || done1 !== 1'b0 || bus1 !== 16'd0) bad++;
      end
      chk("halt hold cycles bad", 128'(bad), 128'(0));

      @(posedge clock);
      #2 reset1 = 1'b0;
      #1 check_reset1("async reset");

      // core 2
      q2.push_back(mk("c2 mvi R1,5",    3, 1, 5,    -1, 0, 0, 0, 0, 32'h0000_0500));
      q2.push_back(mk("c2 mv R6,R1",    2, 1, 5,    -1, 0, 0, 0, 0, 32'h0000_0500));
      q2.push_back(mk("c2 mv R1,R6",    2, 1, 0,    -1, 0, 0, 0, 0, 32'h0000_0000));
      q2.push_back(mk("c2 mvi R0,FFh",  3, 1, 255,  -1, 0, 0, 0, 0, 32'h0000_00FF));
      q2.push_back(mk("c2 mvi R1,1",    3, 1, 1,    -1, 0, 0, 0, 0, 32'h0000_01FF));
      q2.push_back(mk("c2 add wrap",    2, 1, 0,    -1, 0, 0, 0, 0, 32'h0000_0100));

      @(negedge clock);
      run2   = 1'b1;
      reset2 = 1'b1;
      for (int i = 0; i < 500 && (q2.size() != 0 || p2v); i++) @(negedge clock);
      chk("core2 queue drained", 128'(q2.size()), 128'(0));
      run2 = 1'b0;
      repeat (8) @(negedge clock);
      chk("core2 final regs", 128'(regs2), 128'(32'h0000_0100));
      chk("core2 idle Tstep", 128'(tstep2), 128'(0));

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
      $finish;
   end

endmodule
